vga_sync_monitor: RTL and testbench

- Synthesizable checker directly downstream of the VGA pixel/sync generator. Consumes the same hsync/vsync/red/green/blue nets that drive the PMOD pins.
- Measures line length, hsync width, lines per frame and vsync width, then compares them with expected timing.
- Reports lock, sticky errors and per-frame lit-pixel counts. Used on-board (results go to LEDs/UART) and in simulation as a self-check on the generator.

---
 rtl/vga_sync_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
// Timing checker that sits directly behind the VGA pixel/sync generator.
// It measures line length, hsync width, lines per frame and vsync width. The
// measurements are compared with the expected timing. The block reports lock,
// sticky error flags and the number of lit-pixel cycles per frame.
//
// Ports:
//   CLK          system clock, same domain as the generator
//   RST          asynchronous active-high reset
//   hsync/vsync  sync pulses from the generator (polarity set by SYNC_ACTIVE_LOW)
//   red/green/blue colour outputs from the generator
//   clr_err      synchronous pulse clearing the sticky error flags
//   locked       timing matched for at least one full frame
//   err_h        sticky: line length / hsync width mismatch while locked, or hsync lost
//   err_v        sticky: line count / vsync width mismatch while locked
//   err_blank    sticky: colour driven while a sync pulse is active
//   line_len     last measured line length (cycles)
//   hs_width     last measured hsync width (cycles)
//   frame_lines  last measured lines per frame
//   vs_width     last measured vsync width (lines)
//   lit_count    lit cycles in the last complete frame
//   frame_count  complete frames seen (wraps)
//   frame_done   one-cycle pulse when the frame measurements update
module vga_sync_monitor #(
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int CW              = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          red,
  input  logic          green,
  input  logic          blue,
  input  logic          clr_err,
  output logic          locked,
  output logic          err_h,
  output logic          err_v,
  output logic          err_blank,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] frame_lines,
  output logic [CW-1:0] vs_width,
  output logic [CW-1:0] lit_count,
  output logic [CW-1:0] frame_count,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_C     = {CW{1'b1}};
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic          POL_C     = (SYNC_ACTIVE_LOW != 0);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
    if (v == MAX_C) begin
      return v;
    end else begin
      return v + ONE_C;
    end
  endfunction

  logic          hs_q_r, vs_q_r;
  logic          seen_h_r;      // at least one hs_start since reset
  logic          vs_pend_r;     // vs_start seen, waiting for the line that opens the frame
  logic          line_bad_r;    // some line of the current frame mismatched
  logic [CW-1:0] h_cnt_r;
  logic [CW-1:0] hs_w_r;
  logic [CW-1:0] v_cnt_r;
  logic [CW-1:0] vs_hs_cnt_r;   // hs_starts seen during the most recent vsync pulse
  logic [CW-1:0] lit_acc_r;
  state_t        state_r;

  logic hs_s, vs_s, hs_start_s, hs_fall_s, vs_start_s, lit_s;
  logic line_mis_s, frame_mis_s, frame_bad_s, sat_s, report_s;
  logic err_h_ev_s, err_v_ev_s, err_blank_ev_s;

  assign hs_s       = hsync ^ POL_C;
  assign vs_s       = vsync ^ POL_C;
  assign hs_start_s = hs_s & ~hs_q_r;
  assign hs_fall_s  = ~hs_s & hs_q_r;
  assign vs_start_s = vs_s & ~vs_q_r;
  assign lit_s      = red | green | blue;

  // The line that just ended is judged at the hs_start that closes it; the
  // very first hs_start after reset closes no measured line.
  assign line_mis_s  = hs_start_s & seen_h_r &
                       ((h_cnt_r != H_TOTAL_C) | (hs_width != H_SYNC_C));
  assign frame_mis_s = (v_cnt_r != V_TOTAL_C) | (vs_hs_cnt_r != V_SYNC_C);
  // A coincident hs_start closes the last line of the old frame, so its
  // check is folded into the frame verdict.
  assign frame_bad_s = frame_mis_s | line_bad_r | line_mis_s;
  // Saturation only counts as hsync loss while no new line is starting.
  assign sat_s       = (h_cnt_r == MAX_C) & ~hs_start_s;
  assign report_s    = vs_start_s & ~sat_s & (state_r != SEARCH);

  assign err_h_ev_s     = (state_r == LOCKED) & (line_mis_s | sat_s);
  assign err_v_ev_s     = (state_r == LOCKED) & vs_start_s & ~sat_s & frame_mis_s;
  assign err_blank_ev_s = (hs_s | vs_s) & lit_s;

  // Sync history, horizontal/vertical counters and the lit accumulator.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_q_r      <= 1'b0;
      vs_q_r      <= 1'b0;
      seen_h_r    <= 1'b0;
      vs_pend_r   <= 1'b0;
      line_bad_r  <= 1'b0;
      h_cnt_r     <= ZERO_C;
      hs_w_r      <= ZERO_C;
      v_cnt_r     <= ZERO_C;
      vs_hs_cnt_r <= ZERO_C;
      lit_acc_r   <= ZERO_C;
      line_len    <= ZERO_C;
      hs_width    <= ZERO_C;
    end else begin
      hs_q_r   <= hs_s;
      vs_q_r   <= vs_s;
      seen_h_r <= seen_h_r | hs_start_s;

      h_cnt_r <= hs_start_s ? ONE_C : inc_sat(h_cnt_r);
      if (hs_start_s & seen_h_r) begin
        line_len <= h_cnt_r;
      end

      if (hs_start_s) begin
        hs_w_r <= ONE_C;
      end else if (hs_s) begin
        hs_w_r <= inc_sat(hs_w_r);
      end
      if (hs_fall_s) begin
        hs_width <= hs_w_r;
      end

      // The frame's first line is the hs_start coincident with, or first after, vs_start.
      if (hs_start_s) begin
        v_cnt_r   <= (vs_start_s | vs_pend_r) ? ONE_C : inc_sat(v_cnt_r);
        vs_pend_r <= 1'b0;
      end else if (vs_start_s) begin
        vs_pend_r <= 1'b1;
      end

      if (vs_start_s) begin
        vs_hs_cnt_r <= hs_start_s ? ONE_C : ZERO_C;
      end else if (vs_s & hs_start_s) begin
        vs_hs_cnt_r <= inc_sat(vs_hs_cnt_r);
      end

      // The accumulator restarts with the current cycle so no lit cycle is lost.
      if (vs_start_s) begin
        lit_acc_r <= lit_s ? ONE_C : ZERO_C;
      end else if (lit_s) begin
        lit_acc_r <= inc_sat(lit_acc_r);
      end

      if (vs_start_s) begin
        line_bad_r <= 1'b0;
      end else if (line_mis_s) begin
        line_bad_r <= 1'b1;
      end
    end
  end

  // Lock state machine, per-frame results and sticky error flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= SEARCH;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      err_blank   <= 1'b0;
      frame_lines <= ZERO_C;
      vs_width    <= ZERO_C;
      lit_count   <= ZERO_C;
      frame_count <= ZERO_C;
      frame_done  <= 1'b0;
    end else begin
      if (sat_s) begin
        state_r <= SEARCH;
        locked  <= 1'b0;
      end else begin
        case (state_r)
          SEARCH: begin
            locked  <= 1'b0;
            state_r <= vs_start_s ? ACQUIRE : SEARCH;
          end
          ACQUIRE: begin
            if (vs_start_s & ~frame_bad_s) begin
              state_r <= LOCKED;
              locked  <= 1'b1;
            end else begin
              state_r <= ACQUIRE;
              locked  <= 1'b0;
            end
          end
          LOCKED: begin
            if (line_mis_s | (vs_start_s & frame_mis_s)) begin
              state_r <= ACQUIRE;
              locked  <= 1'b0;
            end else begin
              state_r <= LOCKED;
              locked  <= 1'b1;
            end
          end
          default: begin
            state_r <= SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end

      frame_done <= report_s;
      if (report_s) begin
        frame_lines <= v_cnt_r;
        vs_width    <= vs_hs_cnt_r;
        lit_count   <= lit_acc_r;
        frame_count <= frame_count + ONE_C;
      end

      // A new error event in the same cycle as clr_err keeps the flag set.
      err_h     <= (err_h & ~clr_err) | err_h_ev_s;
      err_v     <= (err_v & ~clr_err) | err_v_ev_s;
      err_blank <= (err_blank & ~clr_err) | err_blank_ev_s;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor: an ideal 20x6 generator with
// variations, a scoreboard of per-frame results popped on frame_done, and
// direct checks of lock/error flags at chosen points.
module tb_vga_sync_monitor;

  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          hsync, vsync, red, green, blue, clr_err;
  logic          locked, err_h, err_v, err_blank, frame_done;
  logic [CW-1:0] line_len, hs_width, frame_lines, vs_width, lit_count, frame_count;

  always #5 CLK = ~CLK;

  vga_sync_monitor #(
    .H_TOTAL(20), .H_SYNC(3), .V_TOTAL(6), .V_SYNC(2), .SYNC_ACTIVE_LOW(1), .CW(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .clr_err(clr_err),
    .locked(locked), .err_h(err_h), .err_v(err_v), .err_blank(err_blank),
    .line_len(line_len), .hs_width(hs_width), .frame_lines(frame_lines),
    .vs_width(vs_width), .lit_count(lit_count), .frame_count(frame_count),
    .frame_done(frame_done)
  );

  typedef struct {
    int   lines;
    int   vsw;
    int   lit;
    int   fc;
    logic lck;
    logic eh;
    logic ev;
    logic eb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected report for the frame about to be generated; it appears at the next vs_start.
  task automatic push_exp(input int lines, input int lit,
                          input logic lck, input logic eh, input logic ev, input logic eb);
    exp_t e;
    fc++;
    e.lines = lines; e.vsw = 2; e.lit = lit; e.fc = fc;
    e.lck = lck; e.eh = eh; e.ev = ev; e.eb = eb;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && frame_done) begin
        chk("frame_done_expected", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk($sformatf("f%0d_frame_lines", e.fc), frame_lines, e.lines);
          chk($sformatf("f%0d_vs_width", e.fc), vs_width, e.vsw);
          chk($sformatf("f%0d_lit_count", e.fc), lit_count, e.lit);
          chk($sformatf("f%0d_frame_count", e.fc), frame_count, e.fc);
          chk($sformatf("f%0d_locked", e.fc), locked, e.lck);
          chk($sformatf("f%0d_err_h", e.fc), err_h, e.eh);
          chk($sformatf("f%0d_err_v", e.fc), err_v, e.ev);
          chk($sformatf("f%0d_err_blank", e.fc), err_blank, e.eb);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_h"}, err_h, 0);
    chk({tag, "_err_v"}, err_v, 0);
    chk({tag, "_err_blank"}, err_blank, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_hs_width"}, hs_width, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_vs_width"}, vs_width, 0);
    chk({tag, "_lit_count"}, lit_count, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic cyc(input logic h, input logic v, input logic r, input logic c);
    hsync = h; vsync = v; red = r; clr_err = c;
    @(posedge CLK);
    #1;
  endtask

  // Lines l0..l1-1 of a frame: hsync low for cycles 0-2, vsync low on lines 0-1.
  // red_n lit cycles from cycle 5 on visible lines only (vsync lines are blanked);
  // rs_line gets one red cycle inside hsync; clr_line pulses clr_err at cycle 10.
  task automatic gen_lines(input int l0, input int l1, input int long_line,
                           input int red_n, input int rs_line, input int clr_line);
    for (int i = l0; i < l1; i++) begin
      int len;
      len = (i == long_line) ? 21 : 20;
      for (int c = 0; c < len; c++) begin
        cyc((c >= 3), (i >= 2),
            ((i >= 2) && (c >= 5) && (c < 5 + red_n)) || ((i == rs_line) && (c == 1)),
            ((i == clr_line) && (c == 10)));
      end
    end
  endtask

  task automatic gen_frame(input int n, input int long_line, input int red_n,
                           input int rs_line, input int clr_line);
    gen_lines(0, n, long_line, red_n, rs_line, clr_line);
  endtask

  initial begin
    RST = 1'b1; hsync = 1'b1; vsync = 1'b1;
    red = 1'b0; green = 1'b0; blue = 1'b0; clr_err = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 1'b0;

    // Frame 1's vs_start is discarded; frame 1 is reported at frame 2's vs_start with lock.
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    chk("ideal_line_len", line_len, 20);
    chk("ideal_hs_width", hs_width, 3);
    chk("ideal_frame_lines", frame_lines, 6);
    chk("ideal_vs_width", vs_width, 2);
    chk("ideal_locked", locked, 1);
    chk("ideal_pending", sb_q.size(), 1);

    // 21-cycle line while locked: err_h, lock lost; one clean frame re-locks.
    push_exp(6, 0, 1'b0, 1'b1, 1'b0, 1'b0); gen_frame(6, 3, 0, -1, -1);
    chk("stretch_err_h", err_h, 1);
    chk("stretch_locked", locked, 0);
    push_exp(6, 0, 1'b1, 1'b1, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, 2);
    chk("clr_err_h", err_h, 0);

    // 7-line frame while locked: err_v, lock lost, then re-lock.
    push_exp(7, 0, 1'b0, 1'b0, 1'b1, 1'b0); gen_frame(7, -1, 0, -1, -1);
    push_exp(6, 0, 1'b1, 1'b0, 1'b1, 1'b0); gen_frame(6, -1, 0, -1, -1);

    // Lit pixels outside sync: 4 visible lines x 5 cycles; then one red cycle in hsync.
    push_exp(6, 20, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 5, -1, 2);
    push_exp(6, 21, 1'b1, 1'b0, 1'b0, 1'b1); gen_frame(6, -1, 5, 3, -1);
    gen_frame(6, -1, 0, -1, 2);
    chk("clr_all_err_h", err_h, 0);
    chk("clr_all_err_v", err_v, 0);
    chk("clr_all_err_blank", err_blank, 0);
    chk("pre_hold_locked", locked, 1);
    chk("pre_hold_pending", sb_q.size(), 0);

    // hsync lost: h_cnt saturates -> SEARCH, locked=0, err_h.
    for (int k = 0; k < 70000; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("hold_locked", locked, 0);
    chk("hold_err_h", err_h, 1);
    push_exp(6, 0, 1'b1, 1'b1, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, 2);

    // Reset in the middle of a locked frame.
    gen_lines(0, 3, -1, 0, -1, -1);
    chk("pre_rst_locked", locked, 1);
    RST = 1'b1;
    #1;
    check_zero("mid_rst");
    fc = 0;
    gen_lines(3, 4, -1, 0, -1, -1);
    RST = 1'b0;
    gen_lines(4, 6, -1, 0, -1, -1);
    chk("post_rst_partial_locked", locked, 0);
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    chk("post_rst_one_frame_locked", locked, 0);
    push_exp(6, 0, 1'b1, 1'b0, 1'b0, 1'b0); gen_frame(6, -1, 0, -1, -1);
    gen_frame(6, -1, 0, -1, -1);
    chk("final_locked", locked, 1);
    chk("final_pending", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
